// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG MCU path and the raster read FSM encoding.
package jpeg_pkg;
  localparam int MCU_PER_BLOCK_420 = 6;
  localparam int BLOCK_DIM = 16;
  localparam int MCU_DIM = 8;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 2'd0;
  localparam rd_state_t RD_RUN  = 2'd1;
  localparam rd_state_t RD_LAST = 2'd2;
endpackage

// File: rtl/dp_ram_be.sv
// Simple dual-port RAM with per-lane write enables and a registered, enabled read port.
module dp_ram_be #(
  parameter int NB = 8,
  parameter int LW = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NB-1:0]     wr_be,
  input  logic [NB*LW-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [NB*LW-1:0]  rd_data
);
  logic [NB*LW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (wr_be[b]) mem[wr_addr][b*LW +: LW] <= wr_data[b*LW +: LW];
    // rd_data holds while rd_en is low, so a stalled read stays valid
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/mcu_unbuffer_rd.sv
// Raster read side: walks a buffered 16-line stripe pixel by pixel and emits
// bias-restored YUV with 2:1 chroma replication through a two-stage pipeline.
module mcu_unbuffer_rd
  import jpeg_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int DW = 8,
  parameter logic [DW-1:0] JPEG_BIAS = 8'd128,
  localparam int BW = XW - 4,
  localparam int SW = YW - 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  empty,
  input  logic [XW-1:0]         x_size_m1,
  input  logic [YW-1:0]         y_size_m1,
  input  logic                  hold,
  output logic [1:0]            rptr,
  output logic                  rd_en,
  output logic [BW+5:0]         y_raddr,
  output logic [BW+3:0]         c_raddr,
  input  logic [7:0][DW-1:0]    y_rdata,
  input  logic [7:0][DW-1:0]    u_rdata,
  input  logic [7:0][DW-1:0]    v_rdata,
  output logic [2:0][DW-1:0]    yuv_out,
  output logic                  yuv_out_valid,
  output logic [XW-1:0]         pixel_count,
  output logic [YW-1:0]         line_count,
  output logic                  eof_out
);
  rd_state_t       state;
  logic [XW-1:0]   x;
  logic [3:0]      line;
  logic [SW-1:0]   stripe;
  logic [1:0]      vld_pipe;
  logic [2:0]      s1_ysel, s1_csel;
  logic [XW-1:0]   s1_x;
  logic [YW-1:0]   s1_y;
  logic            s1_eof;
  logic            adv, issue, last_x, last_line, last_stripe;

  assign adv         = ~hold;
  assign issue       = adv & (state == RD_RUN);
  assign last_stripe = stripe == y_size_m1[YW-1:4];
  assign last_line   = line == (last_stripe ? y_size_m1[3:0] : 4'hf);
  assign last_x      = x == x_size_m1;
  assign rd_en       = issue;
  assign y_raddr     = {x[XW-1:4], x[3], line, rptr[0]};
  assign c_raddr     = {x[XW-1:4], line[3:1], rptr[0]};
  assign yuv_out_valid = vld_pipe[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= RD_IDLE;
      x           <= '0;
      line        <= '0;
      stripe      <= '0;
      rptr        <= '0;
      vld_pipe    <= '0;
      s1_ysel     <= '0;
      s1_csel     <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_eof      <= 1'b0;
      yuv_out     <= '0;
      pixel_count <= '0;
      line_count  <= '0;
      eof_out     <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[0], issue};
      case (state)
        RD_IDLE: if (!empty) state <= RD_RUN;
        RD_RUN: begin
          s1_ysel <= x[2:0];
          s1_csel <= x[3:1];
          s1_x    <= x;
          s1_y    <= {stripe, line};
          s1_eof  <= last_x & last_line & last_stripe;
          x       <= last_x ? '0 : x + 1'b1;
          if (last_x) begin
            if (last_line) begin
              // stripe slot is released as its final read is issued
              line   <= '0;
              stripe <= last_stripe ? '0 : stripe + 1'b1;
              rptr   <= rptr + 2'd1;
              state  <= RD_LAST;
            end else begin
              line <= line + 4'd1;
            end
          end
        end
        RD_LAST: state <= empty ? RD_IDLE : RD_RUN;
        default: state <= RD_IDLE;
      endcase
      if (vld_pipe[0]) begin
        yuv_out[0]  <= y_rdata[s1_ysel] + JPEG_BIAS;
        yuv_out[1]  <= u_rdata[s1_csel] + JPEG_BIAS;
        yuv_out[2]  <= v_rdata[s1_csel] + JPEG_BIAS;
        pixel_count <= s1_x;
        line_count  <= s1_y;
      end
      eof_out <= vld_pipe[0] & s1_eof;
    end
  end
endmodule

// File: rtl/mcu_unbuffer.sv
// 4:2:0 MCU rows in, raster YUV out: write-side counters and the double-buffered
// stripe store; the raster walk lives in mcu_unbuffer_rd.
module mcu_unbuffer
  import jpeg_pkg::*;
#(
  parameter int SENSOR_X_SIZE = 720,
  parameter int SENSOR_Y_SIZE = 720,
  parameter int DW = 8,
  parameter logic [DW-1:0] JPEG_BIAS = 8'd128,
  localparam int XW = $clog2(SENSOR_X_SIZE),
  localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic signed [7:0][DW-1:0] do_in,
  input  logic                     do_in_valid,
  output logic                     do_in_hold,
  input  logic [2:0]               do_in_cnt,
  input  logic [XW-1:0]            x_size_m1,
  input  logic [YW-1:0]            y_size_m1,
  output logic [2:0][DW-1:0]       yuv_out,
  output logic                     yuv_out_valid,
  input  logic                     yuv_out_hold,
  output logic [XW-1:0]            yuv_out_pixel_count,
  output logic [YW-1:0]            yuv_out_line_count,
  output logic                     eof_out,
  output logic                     seq_err
);
  localparam int BW = XW - 4;
  localparam int SW = YW - 4;
  localparam int Y_DEPTH = 2 * SENSOR_X_SIZE * BLOCK_DIM / MCU_DIM;
  localparam int C_DEPTH = 2 * (SENSOR_X_SIZE / 2) * MCU_DIM / MCU_DIM;

  logic [2:0]          row, mcu;
  logic [BW-1:0]       blk;
  logic [SW-1:0]       stripe;
  logic [1:0]          wptr, rptr;
  logic                acc, last_row, last_mcu, last_blk, last_stripe, empty, full;
  logic [8*DW-1:0]     wdata;
  logic [BW+5:0]       y_waddr, y_raddr;
  logic [BW+3:0]       c_waddr, c_raddr;
  logic                rd_en;
  logic [7:0][DW-1:0]  y_rdata, u_rdata, v_rdata;

  assign empty       = wptr == rptr;
  assign full        = (wptr[1] != rptr[1]) & (wptr[0] == rptr[0]);
  assign do_in_hold  = full;
  assign acc         = do_in_valid & ~do_in_hold;
  assign last_row    = row == 3'(MCU_DIM - 1);
  assign last_mcu    = mcu == 3'(MCU_PER_BLOCK_420 - 1);
  assign last_blk    = blk == x_size_m1[XW-1:4];
  assign last_stripe = stripe == y_size_m1[YW-1:4];
  assign wdata       = do_in;
  // Y word index: left/right 8x8 from mcu[0], top/bottom half from mcu[1]
  assign y_waddr     = {blk, mcu[0], mcu[1], row, wptr[0]};
  assign c_waddr     = {blk, row, wptr[0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row     <= '0;
      mcu     <= '0;
      blk     <= '0;
      stripe  <= '0;
      wptr    <= '0;
      seq_err <= 1'b0;
    end else if (acc) begin
      if (do_in_cnt != row) seq_err <= 1'b1;
      row <= row + 3'd1;
      if (last_row) begin
        mcu <= last_mcu ? 3'd0 : mcu + 3'd1;
        if (last_mcu) begin
          blk <= last_blk ? '0 : blk + 1'b1;
          if (last_blk) begin
            wptr   <= wptr + 2'd1;
            stripe <= last_stripe ? '0 : stripe + 1'b1;
          end
        end
      end
    end
  end

  dp_ram_be #(.NB(8), .LW(DW), .DEPTH(Y_DEPTH), .AW(BW+6)) u_y_ram (
    .clk(clk), .wr_en(acc & ~mcu[2]), .wr_addr(y_waddr), .wr_be('1), .wr_data(wdata),
    .rd_en(rd_en), .rd_addr(y_raddr), .rd_data(y_rdata));

  dp_ram_be #(.NB(8), .LW(DW), .DEPTH(C_DEPTH), .AW(BW+4)) u_u_ram (
    .clk(clk), .wr_en(acc & (mcu == 3'd4)), .wr_addr(c_waddr), .wr_be('1), .wr_data(wdata),
    .rd_en(rd_en), .rd_addr(c_raddr), .rd_data(u_rdata));

  dp_ram_be #(.NB(8), .LW(DW), .DEPTH(C_DEPTH), .AW(BW+4)) u_v_ram (
    .clk(clk), .wr_en(acc & (mcu == 3'd5)), .wr_addr(c_waddr), .wr_be('1), .wr_data(wdata),
    .rd_en(rd_en), .rd_addr(c_raddr), .rd_data(v_rdata));

  mcu_unbuffer_rd #(.XW(XW), .YW(YW), .DW(DW), .JPEG_BIAS(JPEG_BIAS)) u_rd (
    .clk(clk), .resetn(resetn), .empty(empty), .x_size_m1(x_size_m1), .y_size_m1(y_size_m1),
    .hold(yuv_out_hold), .rptr(rptr), .rd_en(rd_en), .y_raddr(y_raddr), .c_raddr(c_raddr),
    .y_rdata(y_rdata), .u_rdata(u_rdata), .v_rdata(v_rdata), .yuv_out(yuv_out),
    .yuv_out_valid(yuv_out_valid), .pixel_count(yuv_out_pixel_count),
    .line_count(yuv_out_line_count), .eof_out(eof_out));
endmodule

// File: tb/tb_mcu_unbuffer.sv
// Directed bench for mcu_unbuffer: frames are streamed in MCU order from a pixel
// pattern model and the raster output is compared against the same model.
module tb_mcu_unbuffer;
  localparam int XS = 720, YS = 720, DW = 8;
  localparam int XW = $clog2(XS), YW = $clog2(YS);
  localparam int NMAX = 12000;

  logic clk = 1'b0, resetn = 1'b0;
  logic signed [7:0][DW-1:0] do_in;
  logic do_in_valid, do_in_hold;
  logic [2:0] do_in_cnt;
  logic [XW-1:0] x_size_m1;
  logic [YW-1:0] y_size_m1;
  logic [2:0][DW-1:0] yuv_out;
  logic yuv_out_valid, yuv_out_hold;
  logic [XW-1:0] yuv_out_pixel_count;
  logic [YW-1:0] yuv_out_line_count;
  logic eof_out, seq_err;

  int checks = 0, errors = 0;
  int pat = 0, fw = 16, fh = 16, got = 0;
  longint cyc = 0;
  logic [7:0] oy [NMAX], ou [NMAX], ov [NMAX];
  int opc [NMAX], olc [NMAX];
  logic oeof [NMAX];
  longint ocyc [NMAX];

  mcu_unbuffer #(.SENSOR_X_SIZE(XS), .SENSOR_Y_SIZE(YS), .DW(DW), .JPEG_BIAS(8'd128)) dut (
    .clk(clk), .resetn(resetn), .do_in(do_in), .do_in_valid(do_in_valid), .do_in_hold(do_in_hold),
    .do_in_cnt(do_in_cnt), .x_size_m1(x_size_m1), .y_size_m1(y_size_m1), .yuv_out(yuv_out),
    .yuv_out_valid(yuv_out_valid), .yuv_out_hold(yuv_out_hold),
    .yuv_out_pixel_count(yuv_out_pixel_count), .yuv_out_line_count(yuv_out_line_count),
    .eof_out(eof_out), .seq_err(seq_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unbiased pixel values of the reference image
  function automatic logic [7:0] py(input int x, input int y);
    if (pat == 0) return 8'(x + 16 * y);
    return 8'(x + 5 * y);
  endfunction
  function automatic logic [7:0] pu(input int cx, input int cy);
    if (pat == 0) return 8'h40;
    return 8'(3 * cx + 11 * cy);
  endfunction
  function automatic logic [7:0] pv(input int cx, input int cy);
    if (pat == 0) return 8'hC0;
    return 8'(cx ^ (7 * cy));
  endfunction

  function automatic bit pix_ok(input int k);
    int x, y;
    x = k % fw; y = k / fw;
    return (oy[k] === py(x, y)) && (ou[k] === pu(x / 2, y / 2)) && (ov[k] === pv(x / 2, y / 2))
        && (opc[k] == x) && (olc[k] == y) && (oeof[k] === (k == fw * fh - 1));
  endfunction

  task automatic report_px(input string name, input int k);
    int x, y;
    x = k % fw; y = k / fw;
    $display("FAIL %s: pixel %0d got Y=%h U=%h V=%h x=%0d y=%0d eof=%b, expected Y=%h U=%h V=%h x=%0d y=%0d eof=%b",
             name, k, oy[k], ou[k], ov[k], opc[k], olc[k], oeof[k],
             py(x, y), pu(x / 2, y / 2), pv(x / 2, y / 2), x, y, k == fw * fh - 1);
  endtask

  task automatic send_frame(input int w, input int h, input int bad_row, input int max_rows);
    int n, wc, nb, ns, xx, yy;
    logic [7:0] v;
    n = 0; nb = (w - 1) / 16 + 1; ns = (h - 1) / 16 + 1;
    for (int s = 0; s < ns; s++)
      for (int b = 0; b < nb; b++)
        for (int m = 0; m < 6; m++)
          for (int r = 0; r < 8; r++)
            if (n < max_rows) begin
              @(negedge clk);
              do_in_valid = 1'b1;
              do_in_cnt = (n == bad_row) ? 3'(r + 1) : 3'(r);
              for (int i = 0; i < 8; i++) begin
                if (m < 4) begin
                  xx = b * 16 + (m % 2) * 8 + i; yy = s * 16 + (m / 2) * 8 + r; v = py(xx, yy);
                end else begin
                  xx = b * 8 + i; yy = s * 8 + r; v = (m == 4) ? pu(xx, yy) : pv(xx, yy);
                end
                do_in[i] = v ^ 8'h80;
              end
              wc = 0;
              while (do_in_hold && wc < 5000) begin @(negedge clk); wc++; end
              if (do_in_hold) begin
                checks++; errors++;
                $display("FAIL drv_timeout: do_in_hold still 1 at row %0d, expected 0", n);
              end
              n++;
            end
    @(negedge clk);
    do_in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int t;
    t = 0; got = 0;
    while (got < n && t < budget) begin
      @(negedge clk); t++;
      if (yuv_out_valid && !yuv_out_hold && got < NMAX) begin
        oy[got] = yuv_out[0]; ou[got] = yuv_out[1]; ov[got] = yuv_out[2];
        opc[got] = int'(yuv_out_pixel_count); olc[got] = int'(yuv_out_line_count);
        oeof[got] = eof_out; ocyc[got] = cyc;
        got++;
      end
    end
  endtask

  task automatic test_reset;
    x_size_m1 = 15; y_size_m1 = 15;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (yuv_out !== '0) begin errors++; $display("FAIL rst_yuv: got %h, expected 0", yuv_out); end
    checks++; if (yuv_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", yuv_out_valid); end
    checks++; if (yuv_out_pixel_count !== '0 || yuv_out_line_count !== '0)
      begin errors++; $display("FAIL rst_counts: got %0d/%0d, expected 0/0", yuv_out_pixel_count, yuv_out_line_count); end
    checks++; if (eof_out !== 1'b0) begin errors++; $display("FAIL rst_eof: got %b, expected 0", eof_out); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_seq_err: got %b, expected 0", seq_err); end
    checks++; if (do_in_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b, expected 0", do_in_hold); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bad;
    pat = 0; fw = 16; fh = 16; x_size_m1 = 15; y_size_m1 = 15;
    fork
      send_frame(16, 16, -1, 1 << 30);
      collect(256, 3000);
    join
    checks++; if (got !== 256) begin errors++; $display("FAIL basic_count: got %0d pixels, expected 256", got); end
    bad = -1;
    for (int k = 0; k < got; k++) if (bad < 0 && !pix_ok(k)) bad = k;
    checks++; if (bad !== -1) begin errors++; report_px("basic_pixels", bad); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL basic_seq_err: got %b, expected 0", seq_err); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ramp_720;
    int bad;
    longint span;
    pat = 1; fw = 720; fh = 16; x_size_m1 = 719; y_size_m1 = 15;
    fork
      send_frame(720, 16, -1, 1 << 30);
      collect(11520, 20000);
    join
    checks++; if (got !== 11520) begin errors++; $display("FAIL ramp_count: got %0d pixels, expected 11520", got); end
    bad = -1;
    for (int k = 0; k < got; k++) if (bad < 0 && !pix_ok(k)) bad = k;
    checks++; if (bad !== -1) begin errors++; report_px("ramp_pixels", bad); end
    span = (got > 0) ? ocyc[got - 1] - ocyc[0] : -1;
    checks++; if (span !== 64'd11519) begin errors++; $display("FAIL ramp_throughput: got %0d cycles first-to-last, expected 11519", span); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_unaligned;
    int bad, mx, my, extra;
    pat = 1; fw = 20; fh = 12; x_size_m1 = 19; y_size_m1 = 11;
    fork
      send_frame(20, 12, -1, 1 << 30);
      collect(240, 2000);
    join
    extra = 0;
    repeat (50) begin @(negedge clk); if (yuv_out_valid) extra++; end
    checks++; if (got !== 240 || extra !== 0)
      begin errors++; $display("FAIL unaligned_count: got %0d pixels plus %0d extra, expected 240 plus 0", got, extra); end
    bad = -1; mx = 0; my = 0;
    for (int k = 0; k < got; k++) begin
      if (bad < 0 && !pix_ok(k)) bad = k;
      if (opc[k] > mx) mx = opc[k];
      if (olc[k] > my) my = olc[k];
    end
    checks++; if (bad !== -1) begin errors++; report_px("unaligned_pixels", bad); end
    checks++; if (mx !== 19 || my !== 11) begin errors++; $display("FAIL unaligned_max: got %0d/%0d, expected 19/11", mx, my); end
  endtask

  task automatic test_hold;
    int bad, unstable, t;
    bit seen_hold;
    logic [2:0][DW-1:0] s_yuv;
    logic s_v, s_eof;
    logic [XW-1:0] s_pc;
    logic [YW-1:0] s_lc;
    pat = 1; fw = 16; fh = 48; x_size_m1 = 15; y_size_m1 = 47;
    unstable = 0; seen_hold = 1'b0;
    fork
      send_frame(16, 48, -1, 1 << 30);
      collect(768, 8000);
      begin
        t = 0;
        while (got < 100 && t < 3000) begin @(posedge clk); t++; end
        #1 yuv_out_hold = 1'b1;
        @(negedge clk);
        s_yuv = yuv_out; s_v = yuv_out_valid; s_pc = yuv_out_pixel_count; s_lc = yuv_out_line_count; s_eof = eof_out;
        repeat (2000) begin
          @(negedge clk);
          if (yuv_out !== s_yuv || yuv_out_valid !== s_v || yuv_out_pixel_count !== s_pc ||
              yuv_out_line_count !== s_lc || eof_out !== s_eof) unstable++;
          if (do_in_hold) seen_hold = 1'b1;
        end
        @(posedge clk);
        #1 yuv_out_hold = 1'b0;
      end
    join
    checks++; if (seen_hold !== 1'b1) begin errors++; $display("FAIL hold_backpressure: do_in_hold seen=%b, expected 1", seen_hold); end
    checks++; if (unstable !== 0 || s_v !== 1'b1)
      begin errors++; $display("FAIL hold_stable: %0d changed cycles, valid=%b, expected 0 changes, valid=1", unstable, s_v); end
    checks++; if (got !== 768) begin errors++; $display("FAIL hold_count: got %0d pixels, expected 768", got); end
    bad = -1;
    for (int k = 0; k < got; k++) if (bad < 0 && !pix_ok(k)) bad = k;
    checks++; if (bad !== -1) begin errors++; report_px("hold_pixels", bad); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_seq_err;
    int bad;
    pat = 0; fw = 16; fh = 16; x_size_m1 = 15; y_size_m1 = 15;
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_pre: got %b, expected 0", seq_err); end
    fork
      send_frame(16, 16, 2, 1 << 30);
      collect(256, 3000);
    join
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_set: got %b, expected 1", seq_err); end
    bad = -1;
    for (int k = 0; k < got; k++) if (bad < 0 && !pix_ok(k)) bad = k;
    checks++; if (bad !== -1 || got !== 256) begin errors++; $display("FAIL seq_data: got %0d pixels, first bad %0d, expected 256, none", got, bad); end
    repeat (20) @(negedge clk);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b, expected 1", seq_err); end
  endtask

  task automatic test_reset_mid;
    int bad, t;
    pat = 1; fw = 16; fh = 32; x_size_m1 = 15; y_size_m1 = 31;
    send_frame(16, 32, -1, 68);
    t = 0;
    while (!yuv_out_valid && t < 500) begin @(negedge clk); t++; end
    checks++; if (yuv_out_valid !== 1'b1) begin errors++; $display("FAIL rmid_running: valid=%b, expected 1", yuv_out_valid); end
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if ({yuv_out, yuv_out_valid, yuv_out_pixel_count, yuv_out_line_count, eof_out, seq_err, do_in_hold} !== '0)
      begin errors++; $display("FAIL rmid_zero: yuv=%h v=%b pc=%0d lc=%0d eof=%b seq=%b hold=%b, expected all 0",
                               yuv_out, yuv_out_valid, yuv_out_pixel_count, yuv_out_line_count, eof_out, seq_err, do_in_hold); end
    resetn = 1'b1;
    pat = 0; fw = 16; fh = 16; x_size_m1 = 15; y_size_m1 = 15;
    fork
      send_frame(16, 16, -1, 1 << 30);
      collect(256, 3000);
    join
    checks++; if (got !== 256) begin errors++; $display("FAIL rmid_count: got %0d pixels, expected 256", got); end
    bad = -1;
    for (int k = 0; k < got; k++) if (bad < 0 && !pix_ok(k)) bad = k;
    checks++; if (bad !== -1) begin errors++; report_px("rmid_pixels", bad); end
  endtask

  initial begin
    do_in = '0; do_in_valid = 1'b0; do_in_cnt = '0; yuv_out_hold = 1'b0;
    x_size_m1 = 15; y_size_m1 = 15;
    test_reset;
    test_basic;
    test_ramp_720;
    test_unaligned;
    test_hold;
    test_seq_err;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
